// File: rtl/line_mem_slave_pkg.sv
// Shared line-bus types for the cache-line memory path.
// Used by the line responder and its neighbours on the 128-bit bus.
package line_mem_slave_pkg;

  localparam int LINE_BYTES = 16;

  typedef logic [127:0] line_t;
  typedef logic [15:0]  line_be_t;
  typedef logic [27:0]  line_addr_t;

endpackage

// File: rtl/line_mem_slave_if.sv
// Avalon-MM 128-bit line bus between cache-side masters and line responders.
interface line_mem_slave_if;
  import line_mem_slave_pkg::*;

  logic [31:0] address;
  logic        read;
  logic        write;
  line_t       writedata;
  line_be_t    byteenable;
  line_t       readdata;
  logic        waitrequest;

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, waitrequest
  );

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, waitrequest
  );

endinterface

// File: rtl/line_mem_slave_lfsr16.sv
// 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1, stepping only when adv is high.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] state
);

  always_ff @(posedge clk) begin
    if (rst)
      state <= SEED;
    else if (adv)
      state <= {1'b0, state[15:1]} ^ (state[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/line_mem_slave.sv
// Avalon-MM line responder: byte-enabled line RAM behind a fixed plus
// optionally randomised waitrequest delay, with sticky range/protocol flags.
module line_mem_slave
  import line_mem_slave_pkg::*;
#(
  parameter logic [31:0] BASE         = 32'h0000_0000,
  parameter int          DEPTH        = 1024,
  parameter int          LATENCY      = 2,
  parameter int          RANDOM_STALL = 0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  line_mem_slave_if.slave  avl,
  output logic             err_range,
  output logic             err_proto
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state, state_nxt;
  logic [8:0]  cnt, cnt_nxt;
  logic [8:0]  n_load;
  logic [15:0] lfsr;
  logic        unused_lfsr_hi;

  logic [31:0] lat_addr_p0;
  logic        lat_rd_p0, lat_wr_p0, lat_in_range_p0;
  line_t       lat_wd_p0;
  line_be_t    lat_be_p0;

  logic        req, capture, hold_broken, rd_launch;
  logic [31:0] rd_addr;

  line_t mem [DEPTH];

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 4) < 32'(DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] line_idx(input logic [31:0] a);
    return IDX_W'((a - BASE) >> 4);
  endfunction

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .adv   (capture),
    .state (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[15:3];

  assign req     = avl.read | avl.write;
  assign capture = (state == IDLE) && req;
  assign n_load  = 9'(LATENCY) + ((RANDOM_STALL != 0) ? {6'b0, lfsr[2:0]} : 9'd0);

  assign hold_broken = {avl.address, avl.read, avl.write, avl.writedata, avl.byteenable} !=
                       {lat_addr_p0, lat_rd_p0, lat_wr_p0, lat_wd_p0, lat_be_p0};

  assign avl.waitrequest = (state != ACK);

  // WAIT spends cnt cycles; a zero load skips straight to ACK.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req) begin
        cnt_nxt   = n_load;
        state_nxt = (n_load == 9'd0) ? ACK : WAIT;
      end
      WAIT: begin
        cnt_nxt = cnt - 9'd1;
        if (cnt == 9'd1) state_nxt = ACK;
      end
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // RAM read launched in the cycle whose successor is ACK.
  assign rd_addr   = (state == IDLE) ? avl.address : lat_addr_p0;
  assign rd_launch = (state_nxt == ACK) && ((state == IDLE) ? avl.read : lat_rd_p0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      err_range     <= 1'b0;
      err_proto     <= 1'b0;
      avl.readdata  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (capture && !in_range(avl.address))
        err_range <= 1'b1;
      if ((capture && avl.read && avl.write) || ((state == WAIT) && hold_broken))
        err_proto <= 1'b1;
      if (rd_launch)
        avl.readdata <= in_range(rd_addr) ? mem[line_idx(rd_addr)] : '0;
    end
  end

  // Request capture stage
  always_ff @(posedge clk) begin
    if (capture) begin
      lat_addr_p0     <= avl.address;
      lat_rd_p0       <= avl.read;
      lat_wr_p0       <= avl.write;
      lat_wd_p0       <= avl.writedata;
      lat_be_p0       <= avl.byteenable;
      lat_in_range_p0 <= in_range(avl.address);
    end
  end

  // Write commit in ACK; a simultaneous read+write was taken as a read.
  always_ff @(posedge clk) begin
    if (!rst && (state == ACK) && lat_wr_p0 && !lat_rd_p0 && lat_in_range_p0) begin
      for (int i = 0; i < LINE_BYTES; i++)
        if (lat_be_p0[i])
          mem[line_idx(lat_addr_p0)][8*i +: 8] <= lat_wd_p0[8*i +: 8];
    end
  end

endmodule

// File: doc/line_mem_slave.md
Name: line_mem_slave

Overview:
- 128-bit Avalon-MM line responder: the slave end of the cache-line memory bus that the cache/`mem_interconnect` masters drive.
- Backs a line-granular RAM and adds a configurable base latency plus optional pseudo-random stall injection.
- Replaces testbench-driven waitrequest/readdata in simulation platforms and serves as a small on-chip line store in synthesis.
- Flags protocol violations and out-of-range accesses for the verification bench.

Parameters:
- BASE, 32'h0000_0000: byte address of line 0; must be 16-byte aligned.
- DEPTH, 1024: number of 128-bit lines; power of two, at least 2.
- LATENCY, 2: waitrequest-high cycles added after request capture, range 0..255.
- RANDOM_STALL, 0: when 1, adds 0..7 extra stall cycles per transfer from an LFSR.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock; everything sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- avl_address  in  32  byte address; bits [3:0] ignored.
- avl_read  in  1  read request.
- avl_write  in  1  write request.
- avl_writedata  in  128  write line.
- avl_byteenable  in  16  bit i enables byte i of the line (bits [8i+7:8i]).
- avl_readdata  out  128  read line; valid only while avl_waitrequest=0 for a read.
- avl_waitrequest  out  1  0 only during the single acceptance cycle.
- err_range  out  1  sticky: an access fell outside BASE..BASE+16*DEPTH-1.
- err_proto  out  1  sticky: the master broke Avalon hold rules.

Behaviour:
- Reset state: FSM=IDLE, avl_waitrequest=1, avl_readdata=0, err_range=0, err_proto=0, LFSR=LFSR_SEED. RAM contents are not cleared.
- avl_waitrequest = (state != ACK), registered-state decode, glitch-free.
- IDLE:
  - On read|write, latch address, op, writedata and byteenable.
  - Load counter = LATENCY + (RANDOM_STALL ? lfsr[2:0] : 0), advance the LFSR, go to WAIT.
- WAIT:
  - Counter decrements each cycle; when it is 0, go to ACK.
  - For a read, the RAM read is launched the cycle before ACK so readdata is registered in ACK.
- ACK (one cycle): waitrequest=0.
  - Write: commit enabled bytes at the end of this cycle.
  - Read: avl_readdata holds the line.
  - Next state is always IDLE, so at least one waitrequest-high cycle separates transfers.
- Latency: request seen in IDLE at cycle t is accepted at cycle t+1+N, where N is the loaded counter value (N=0 → t+1). Peak throughput is 1 transfer per 2 cycles.
- avl_readdata after ACK: holds its last value; the bench must not rely on it.
- Line index = (address - BASE) >> 4, DEPTH bits; 32-bit subtraction with no wrap. An address below BASE counts as out of range.
- Out-of-range access: normal handshake and timing, writes dropped, reads return 0, err_range set.
- read & write both high in IDLE: treated as a read, err_proto set.
- In WAIT, any change of address, read, write, writedata or byteenable versus the latched copy, or both request lines dropping: err_proto set. The latched transaction completes unchanged.
- byteenable=0 on a write: legal; completes with no RAM change.
- Read after write to the same line: the next read sees the new data; there is no bypass hazard because a write commits before IDLE.
- rst mid-transaction: back to IDLE next cycle, transaction dropped, no partial write.
- err_* flags clear only on rst.

Decomposition:
- Add to the shared cache defs package (cache/defs.sv):
  - `line_t` (logic[127:0]), `line_be_t` (logic[15:0]), `line_addr_t` (logic[27:0], line-granular address);
  - constant `LINE_BYTES=16`.
- FSM state enum is local.
- One sub-module, `lfsr16`: Galois x^16+x^14+x^13+x^11+1 with advance enable and seed parameter; reused by future stress benches.
- RAM is inferred in-module as a byte-enabled array.

Test Plan:
- LATENCY=2, RANDOM_STALL=0; write 0x...DEADBEEF, be=16'hFFFF @ BASE+0x20, then read the same address -> each accepted 3 cycles after presentation; readdata equals written line; err flags stay 0.
- Write line A, then write B with be=16'h000F to the same line, read -> bytes 0-3 from B, 4-15 from A.
- Read @ BASE+16*DEPTH and @ BASE-16 -> readdata=0, normal handshake, err_range=1; RAM unchanged (verify by in-range read).
- read&write asserted together; separately, address changed mid-WAIT -> err_proto=1; original latched transaction completes with correct data.
- RANDOM_STALL=1, 10k random transfers against a scoreboard -> data matches; every acceptance delay within [LATENCY+1, LATENCY+8].
- Assert rst in WAIT of a write -> waitrequest stays 1, IDLE next cycle, target line unchanged, err flags 0.
